// File: rtl/regfile_bypass.sv
// regfile_bypass: two-read one-write register file with busy scoreboard, write forwarding and sticky range error
module regfile_bypass #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW = 3,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             busy_a,
  output logic             busy_b,
  output logic             err
);
  localparam logic [AW:0] LIM = DEPTH[AW:0];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic wr_in, rsv_in, a_in, b_in, wr_ok, rsv_ok, hit_a, hit_b, rsv_a, rsv_b, bad;
  always_comb begin
    wr_in = {1'b0, wr_addr} < LIM;
    rsv_in = {1'b0, rsv_addr} < LIM;
    a_in = {1'b0, rd_addr_a} < LIM;
    b_in = {1'b0, rd_addr_b} < LIM;
    wr_ok = rst && wr_en && wr_in && !(ZERO_REG != 0 && wr_addr == '0);
    rsv_ok = rsv_en && rsv_in && !(ZERO_REG != 0 && rsv_addr == '0);
    hit_a = BYPASS != 0 && wr_ok && wr_addr == rd_addr_a;
    hit_b = BYPASS != 0 && wr_ok && wr_addr == rd_addr_b;
    rsv_a = rsv_ok && rsv_addr == rd_addr_a;
    rsv_b = rsv_ok && rsv_addr == rd_addr_b;
    rd_data_a = !a_in ? '0 : hit_a ? wr_data : mem[rd_addr_a];
    rd_data_b = !b_in ? '0 : hit_b ? wr_data : mem[rd_addr_b];
    busy_a = a_in && (hit_a ? rsv_a : busy[rd_addr_a]);
    busy_b = b_in && (hit_b ? rsv_b : busy[rd_addr_b]);
    bad = (wr_en && !wr_in) || (rsv_en && !rsv_in) || !a_in || !b_in;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
      err <= 1'b0;
    end else begin
      if (wr_ok) mem[wr_addr] <= wr_data;
      busy <= (busy & ~(DEPTH'(wr_ok) << wr_addr)) | (DEPTH'(rsv_ok) << rsv_addr);
      err <= err | bad;
    end
  end
endmodule
